register_schreib_arbiter: RTL and testbench

Shares the single write port of the 64×32 register file between the two writeback sources, the ALU and the load unit, and tracks which destination registers still have a write outstanding. Requests use a valid/ready handshake and are arbitrated round-robin. The winner is driven to the register file as a registered write command. A busy scoreboard, set at instruction issue and cleared when the write reaches the register file, lets the decode stage stall on read-after-write hazards.

---
 rtl/register_schreib_arbiter.sv | 103 ++++++++++
 tb/tb_register_schreib_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/register_schreib_arbiter.sv
// register_schreib_arbiter
// Shares the single write port of the register file between the ALU and the
// load unit, using round-robin arbitration. It also keeps a busy scoreboard
// so that decode can stall on read-after-write hazards.
//
// Ports
//   Clock, Reset (async, active low)
//   AluGueltig/AluRegister/AluDaten -> AluBereit     : ALU writeback request
//   LadeGueltig/LadeRegister/LadeDaten -> LadeBereit : load writeback request
//   ZielRegister/ZielDaten/Schreibsignal             : registered write command
//   ReservierGueltig/ReservierRegister               : issue-time reservation
//   AbfrageRegister1/2 -> Belegt1/2                  : combinational busy lookup
module register_schreib_arbiter #(
   parameter int DATENBREITE  = 32,
   parameter int ADRESSBREITE = 6
) (
   input  logic                    Clock,
   input  logic                    Reset,
   input  logic                    AluGueltig,
   input  logic [ADRESSBREITE-1:0] AluRegister,
   input  logic [DATENBREITE-1:0]  AluDaten,
   output logic                    AluBereit,
   input  logic                    LadeGueltig,
   input  logic [ADRESSBREITE-1:0] LadeRegister,
   input  logic [DATENBREITE-1:0]  LadeDaten,
   output logic                    LadeBereit,
   output logic [ADRESSBREITE-1:0] ZielRegister,
   output logic [DATENBREITE-1:0]  ZielDaten,
   output logic                    Schreibsignal,
   input  logic                    ReservierGueltig,
   input  logic [ADRESSBREITE-1:0] ReservierRegister,
   input  logic [ADRESSBREITE-1:0] AbfrageRegister1,
   input  logic [ADRESSBREITE-1:0] AbfrageRegister2,
   output logic                    Belegt1,
   output logic                    Belegt2
);

   localparam int NREG = 1 << ADRESSBREITE;

   typedef enum logic {
      QUELLE_ALU  = 1'b0,
      QUELLE_LADE = 1'b1
   } quelle_e;

   quelle_e                 letzter_q;
   logic [ADRESSBREITE-1:0] ziel_reg_q;
   logic [DATENBREITE-1:0]  ziel_daten_q;
   logic                    schreib_q;
   logic [NREG-1:0]         belegt_q, belegt_d;
   logic                    alu_gewinnt, lade_gewinnt;

   // The source that did not win last time takes a conflict. An uncontested
   // source always wins.
   assign alu_gewinnt  = AluGueltig  & (~LadeGueltig | (letzter_q == QUELLE_LADE));
   assign lade_gewinnt = LadeGueltig & (~AluGueltig  | (letzter_q == QUELLE_ALU));

   // Gate with Reset so that neither source sees an accept while reset is held.
   assign AluBereit  = Reset & alu_gewinnt;
   assign LadeBereit = Reset & lade_gewinnt;

   // The clear is applied first and the set second, so a reservation made on
   // the same edge as the commit wins. The newer instruction owns the register.
   always_comb begin
      belegt_d = belegt_q;
      if (schreib_q)
         belegt_d[ziel_reg_q] = 1'b0;
      if (ReservierGueltig)
         belegt_d[ReservierRegister] = 1'b1;
      belegt_d[0] = 1'b0;
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         letzter_q    <= QUELLE_LADE;
         ziel_reg_q   <= '0;
         ziel_daten_q <= '0;
         schreib_q    <= 1'b0;
         belegt_q     <= '0;
      end else begin
         belegt_q <= belegt_d;
         if (alu_gewinnt) begin
            ziel_reg_q   <= AluRegister;
            ziel_daten_q <= AluDaten;
            schreib_q    <= |AluRegister;   // r0 completes the handshake but is not written
            letzter_q    <= QUELLE_ALU;
         end else if (lade_gewinnt) begin
            ziel_reg_q   <= LadeRegister;
            ziel_daten_q <= LadeDaten;
            schreib_q    <= |LadeRegister;
            letzter_q    <= QUELLE_LADE;
         end else begin
            schreib_q    <= 1'b0;
         end
      end
   end

   assign ZielRegister  = ziel_reg_q;
   assign ZielDaten     = ziel_daten_q;
   assign Schreibsignal = schreib_q;
   assign Belegt1       = belegt_q[AbfrageRegister1];
   assign Belegt2       = belegt_q[AbfrageRegister2];

endmodule

// File: tb/tb_register_schreib_arbiter.sv
// Testbench for register_schreib_arbiter: directed scenarios with literal
// expectations, followed by randomized traffic. The DUT is checked on every
// cycle against a behavioural model (a busy array, a last-winner flag and the
// pending write command).
module tb_register_schreib_arbiter;
   localparam int DW = 32;
   localparam int AW = 6;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          AluGueltig, LadeGueltig, AluBereit, LadeBereit;
   logic [AW-1:0] AluRegister, LadeRegister, ZielRegister;
   logic [DW-1:0] AluDaten, LadeDaten, ZielDaten;
   logic          Schreibsignal, ReservierGueltig, Belegt1, Belegt2;
   logic [AW-1:0] ReservierRegister, AbfrageRegister1, AbfrageRegister2;

   register_schreib_arbiter #(.DATENBREITE(DW), .ADRESSBREITE(AW)) dut (
      .Clock(Clock), .Reset(Reset),
      .AluGueltig(AluGueltig), .AluRegister(AluRegister), .AluDaten(AluDaten), .AluBereit(AluBereit),
      .LadeGueltig(LadeGueltig), .LadeRegister(LadeRegister), .LadeDaten(LadeDaten), .LadeBereit(LadeBereit),
      .ZielRegister(ZielRegister), .ZielDaten(ZielDaten), .Schreibsignal(Schreibsignal),
      .ReservierGueltig(ReservierGueltig), .ReservierRegister(ReservierRegister),
      .AbfrageRegister1(AbfrageRegister1), .AbfrageRegister2(AbfrageRegister2),
      .Belegt1(Belegt1), .Belegt2(Belegt2)
   );

   always #5 Clock = ~Clock;

   int errors = 0;
   int checks = 0;

   // behavioural model
   bit            mbusy [64];
   bit            mlast;          // 1: load unit won last
   bit            mwe;
   logic [AW-1:0] maddr;
   logic [DW-1:0] mdata;
   bit            acc_a, acc_l;   // what was accepted at the last edge

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      foreach (mbusy[i]) mbusy[i] = 1'b0;
      mlast = 1'b1;
      mwe   = 1'b0;
      maddr = '0;
      mdata = '0;
      acc_a = 1'b0;
      acc_l = 1'b0;
   endtask

   function automatic bit want_alu();
      return AluGueltig && (!LadeGueltig || mlast);
   endfunction
   function automatic bit want_lade();
      return LadeGueltig && (!AluGueltig || !mlast);
   endfunction

   task automatic compare();
      chk("AluBereit",     {31'd0, AluBereit},     {31'd0, want_alu()});
      chk("LadeBereit",    {31'd0, LadeBereit},    {31'd0, want_lade()});
      chk("Schreibsignal", {31'd0, Schreibsignal}, {31'd0, mwe});
      chk("ZielRegister",  {26'd0, ZielRegister},  {26'd0, maddr});
      chk("ZielDaten",     ZielDaten,              mdata);
      chk("Belegt1",       {31'd0, Belegt1},       {31'd0, mbusy[AbfrageRegister1]});
      chk("Belegt2",       {31'd0, Belegt2},       {31'd0, mbusy[AbfrageRegister2]});
   endtask

   // The caller drives inputs just after an edge. This task compares the
   // outputs mid-cycle, advances through the next edge, updates the model,
   // and returns 1 time unit past that edge.
   task automatic step();
      bit ga, gl;
      #1;
      compare();
      ga = want_alu();
      gl = want_lade();
      @(posedge Clock);
      if (mwe) mbusy[maddr] = 1'b0;
      if (ReservierGueltig && ReservierRegister != 0) mbusy[ReservierRegister] = 1'b1;
      if (ga) begin
         maddr = AluRegister;  mdata = AluDaten;  mwe = (AluRegister != 0);  mlast = 1'b0;
      end else if (gl) begin
         maddr = LadeRegister; mdata = LadeDaten; mwe = (LadeRegister != 0); mlast = 1'b1;
      end else begin
         mwe = 1'b0;
      end
      acc_a = ga;
      acc_l = gl;
      #1;
   endtask

   initial begin
      logic [AW-1:0] r;
      Reset = 1'b0;
      AluGueltig = 1'b1;  AluRegister = 6'd1;  AluDaten = 32'h1;
      LadeGueltig = 1'b1; LadeRegister = 6'd2; LadeDaten = 32'h2;
      ReservierGueltig = 1'b0; ReservierRegister = '0;
      AbfrageRegister1 = 6'd7; AbfrageRegister2 = 6'd0;
      model_reset();

      // Reset held with both sources valid
      repeat (2) @(posedge Clock);
      #2;
      chk("rst_AluBereit",  {31'd0, AluBereit},     32'd0);
      chk("rst_LadeBereit", {31'd0, LadeBereit},    32'd0);
      chk("rst_Schreib",    {31'd0, Schreibsignal}, 32'd0);
      chk("rst_Belegt1",    {31'd0, Belegt1},       32'd0);
      @(negedge Clock);
      Reset = 1'b1;

      // Round-robin starting from reset: ALU first
      AluRegister = 6'd5;  AluDaten = 32'h11111111;
      LadeRegister = 6'd6; LadeDaten = 32'h22222222;
      #1;
      chk("post_rst_AluBereit",  {31'd0, AluBereit},  32'd1);
      chk("post_rst_LadeBereit", {31'd0, LadeBereit}, 32'd0);
      @(posedge Clock); #1;
      // the first grant happened at this edge; account for it in the model
      mwe = 1'b1; maddr = 6'd5; mdata = 32'h11111111; mlast = 1'b0;
      chk("rr0_reg", {26'd0, ZielRegister}, 32'd5);
      for (int i = 1; i < 4; i++) begin
         step();
         chk("rr_we",   {31'd0, Schreibsignal}, 32'd1);
         chk("rr_reg",  {26'd0, ZielRegister}, (i % 2) ? 32'd6 : 32'd5);
         chk("rr_data", ZielDaten, (i % 2) ? 32'h22222222 : 32'h11111111);
      end
      AluGueltig = 1'b0; LadeGueltig = 1'b0;
      step();

      // Scoreboard timing on r7
      ReservierGueltig = 1'b1; ReservierRegister = 6'd7; AbfrageRegister1 = 6'd7;
      step();                                 // edge 0
      ReservierGueltig = 1'b0;
      chk("sb_set", {31'd0, Belegt1}, 32'd1);
      step(); step();                         // edges 1, 2
      AluGueltig = 1'b1; AluRegister = 6'd7; AluDaten = 32'hDEADBEEF;
      step();                                 // edge 3: transfer
      AluGueltig = 1'b0;
      chk("sb_we",    {31'd0, Schreibsignal}, 32'd1);
      chk("sb_data",  ZielDaten, 32'hDEADBEEF);
      chk("sb_busy4", {31'd0, Belegt1}, 32'd1);
      step();                                 // edge 4: commit
      chk("sb_clear", {31'd0, Belegt1}, 32'd0);

      // Register 0: handshake completes but nothing is written or reserved
      LadeGueltig = 1'b1; LadeRegister = 6'd0; LadeDaten = 32'hFFFFFFFF;
      #1;
      chk("r0_bereit", {31'd0, LadeBereit}, 32'd1);
      step();
      LadeGueltig = 1'b0;
      chk("r0_we", {31'd0, Schreibsignal}, 32'd0);
      ReservierGueltig = 1'b1; ReservierRegister = 6'd0; AbfrageRegister2 = 6'd0;
      step();
      ReservierGueltig = 1'b0;
      chk("r0_busy", {31'd0, Belegt2}, 32'd0);

      // Set/clear collision on r9
      ReservierGueltig = 1'b1; ReservierRegister = 6'd9; AbfrageRegister1 = 6'd9;
      step();
      ReservierGueltig = 1'b0;
      AluGueltig = 1'b1; AluRegister = 6'd9; AluDaten = 32'h99;
      step();
      AluGueltig = 1'b0;
      ReservierGueltig = 1'b1; ReservierRegister = 6'd9;  // same edge as the commit
      step();
      ReservierGueltig = 1'b0;
      chk("collide_busy", {31'd0, Belegt1}, 32'd1);

      // Mid-operation reset
      AluGueltig = 1'b1; AluRegister = 6'd3; AluDaten = 32'h33;
      step();
      AluGueltig = 1'b0;
      chk("mr_we_before", {31'd0, Schreibsignal}, 32'd1);
      #2;
      Reset = 1'b0;
      #1;
      chk("mr_we_async", {31'd0, Schreibsignal}, 32'd0);
      chk("mr_busy",     {31'd0, Belegt1},       32'd0);
      @(negedge Clock);
      Reset = 1'b1;
      model_reset();
      AluGueltig = 1'b1;  AluRegister = 6'd1;  AluDaten = 32'hA1;
      LadeGueltig = 1'b1; LadeRegister = 6'd2; LadeDaten = 32'hB2;
      step();
      chk("mr_first_grant", {26'd0, ZielRegister}, 32'd1);

      // Randomized traffic with the model compared every cycle
      for (int c = 0; c < 400; c++) begin
         if (!AluGueltig || acc_a) begin
            AluGueltig  = ($urandom % 4) != 0;
            AluRegister = AW'($urandom_range(0, 63));
            AluDaten    = $urandom;
         end
         if (!LadeGueltig || acc_l) begin
            LadeGueltig  = ($urandom % 3) != 0;
            LadeRegister = AW'($urandom_range(0, 63));
            LadeDaten    = $urandom;
         end
         r = AW'($urandom_range(0, 63));
         ReservierRegister = r;
         ReservierGueltig  = (($urandom % 3) == 0) && !mbusy[r];
         AbfrageRegister1  = AW'($urandom_range(0, 63));
         AbfrageRegister2  = ($urandom % 2) ? AluRegister : AW'($urandom_range(0, 63));
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
